uart_tx_arbiter: RTL and testbench

Shares one serial line between two nibble requesters and serializes each granted nibble into the frame format consumed by the team's even-parity line checker:
- Frame: start(0), 4 data bits LSB first, even-parity bit, stop(1). Line idles high.
- Round-robin arbitration with a configurable minimum idle gap between frames.
- Sits between the producing logic and the serial pin/checker.

---
 rtl/uart_tx_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one serial line between two nibble requesters. A
//            round-robin arbiter picks a requester, latches its nibble and
//            sends it as a 7-bit-time frame:
//              start(0), d0, d1, d2, d3 (LSB first), even parity, stop(1).
//            The line idles high. IDLE_GAP idle bit times follow every stop
//            bit before the next arbitration.
//
// Parameters:
//   IDLE_GAP  minimum idle cycles (tx=1) after each stop bit, legal 0..15.
//             With IDLE_GAP=0 the STOP cycle itself arbitrates, so frames
//             can run back to back with no idle bit between them.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-low reset (0 = reset)
//   req0 / req1  in   frame request, held until the matching gnt
//   data0/data1  in   [3:0] nibble, stable while the request is high
//   gnt0 / gnt1  out  one-cycle pulse in the START cycle of the frame
//   tx           out  serial line
//   busy         out  high in every state other than IDLE
//   done         out  high during the STOP cycle
//   inj_err      in   only with UART_ARB_PARITY_INJECT_EN: sampled with the
//                     data at the grant edge; when 1 the parity bit of that
//                     frame is inverted.
//
// Build option:
//   UART_ARB_PARITY_INJECT_EN  adds inj_err and parity-error injection.
//
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int unsigned IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [3:0] data0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [3:0] data1,
  output logic       gnt1,
  output logic       tx,
  output logic       busy,
  output logic       done
`ifdef UART_ARB_PARITY_INJECT_EN
  ,
  input  logic       inj_err
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // Without a gap the STOP cycle becomes an arbitration point.
  localparam logic       HAS_GAP  = (IDLE_GAP != 0);
  // GAP counts down to zero; the value loaded covers IDLE_GAP cycles.
  localparam logic [3:0] GAP_LOAD = (IDLE_GAP == 0) ? 4'd0 : 4'(IDLE_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t     state_q,   state_d;
  logic [1:0] bit_cnt_q, bit_cnt_d;   // data bit index within S_DATA
  logic [3:0] shift_q,   shift_d;     // latched nibble, shifted out LSB first
  logic       par_q,     par_d;       // parity bit to send for this frame
  logic       sel_q,     sel_d;       // requester owning the frame in flight
  logic       rr_q,      rr_d;        // round-robin pointer: preferred on tie
  logic [3:0] gap_q,     gap_d;       // remaining GAP cycles minus one

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic       any_req;
  logic       pick1;
  logic [3:0] pick_data;
  logic       inj_bit;
  logic       do_grant;

`ifdef UART_ARB_PARITY_INJECT_EN
  assign inj_bit = inj_err;
`else
  assign inj_bit = 1'b0;
`endif

  // Requester 1 wins when it is alone, or when both ask and the pointer
  // names it.
  assign any_req   = req0 | req1;
  assign pick1     = req1 & (~req0 | rr_q);
  assign pick_data = pick1 ? data1 : data0;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    gap_d     = gap_q;
    do_grant  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        do_grant = any_req;
      end
      S_START: begin
        state_d   = S_DATA;
        bit_cnt_d = 2'd0;
      end
      S_DATA: begin
        shift_d   = {1'b0, shift_q[3:1]};
        bit_cnt_d = bit_cnt_q + 2'd1;
        if (bit_cnt_q == 2'd3) begin
          state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        state_d = S_STOP;
      end
      S_STOP: begin
        if (HAS_GAP) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else if (any_req) begin
          do_grant = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        // The final GAP cycle only returns to IDLE; it never grants.
        if (gap_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (do_grant) begin
      state_d = S_START;
      shift_d = pick_data;
      // Parity is captured now because the shift register is consumed
      // while the data bits go out.
      par_d   = (^pick_data) ^ inj_bit;
      sel_d   = pick1;
      rr_d    = ~pick1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 2'd0;
      shift_q   <= 4'd0;
      par_q     <= 1'b0;
      sel_q     <= 1'b0;
      rr_q      <= 1'b0;
      gap_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      sel_q     <= sel_d;
      rr_q      <= rr_d;
      gap_q     <= gap_d;
    end
  end

  // --------------------------------------------------------------------------
  // Moore outputs, decoded from registers only
  // --------------------------------------------------------------------------
  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    done = 1'b0;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_START: begin
        tx   = 1'b0;
        gnt0 = ~sel_q;
        gnt1 = sel_q;
      end
      S_DATA: begin
        tx = shift_q[0];
      end
      S_PARITY: begin
        tx = par_q;
      end
      S_STOP: begin
        done = 1'b1;
      end
      S_GAP: begin
        tx = 1'b1;
      end
      default: begin
        tx   = 1'b1;
        busy = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench. Two instances (IDLE_GAP=1 and IDLE_GAP=0)
//            are compared every cycle against a frame-level reference model
//            that expands each grant into its list of expected bit times.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [1:0]      r0, r1;
  logic [1:0][3:0] d0, d1;
`ifdef UART_ARB_PARITY_INJECT_EN
  logic [1:0]      ij;
`endif
  wire  [1:0]      g0, g1, tx, busy, done;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(.IDLE_GAP(1)) dut_gap1 (
    .clk   (clk),
    .reset (reset),
    .req0  (r0[0]),
    .data0 (d0[0]),
    .gnt0  (g0[0]),
    .req1  (r1[0]),
    .data1 (d1[0]),
    .gnt1  (g1[0]),
    .tx    (tx[0]),
    .busy  (busy[0]),
    .done  (done[0])
`ifdef UART_ARB_PARITY_INJECT_EN
    ,
    .inj_err (ij[0])
`endif
  );

  uart_tx_arbiter #(.IDLE_GAP(0)) dut_gap0 (
    .clk   (clk),
    .reset (reset),
    .req0  (r0[1]),
    .data0 (d0[1]),
    .gnt0  (g0[1]),
    .req1  (r1[1]),
    .data1 (d1[1]),
    .gnt1  (g1[1]),
    .tx    (tx[1]),
    .busy  (busy[1]),
    .done  (done[1])
`ifdef UART_ARB_PARITY_INJECT_EN
    ,
    .inj_err (ij[1])
`endif
  );

  // --------------------------------------------------------------------------
  // Reference model: one entry per expected bit time
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
    logic g0;
    logic g1;
    logic arb;   // this cycle may accept a request at its closing edge
  } ent_t;

  localparam ent_t IDLE_E = '{tx: 1'b1, busy: 1'b0, done: 1'b0, g0: 1'b0, g1: 1'b0, arb: 1'b1};

  ent_t mq0[$];
  ent_t mq1[$];
  ent_t cur[2];
  int   rr[2];

  function automatic int gap_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  task automatic push_e(input int k, input ent_t e);
    if (k == 0) mq0.push_back(e);
    else        mq1.push_back(e);
  endtask

  task automatic pop_e(input int k, output ent_t e);
    e = IDLE_E;
    if (k == 0) begin
      if (mq0.size() > 0) e = mq0.pop_front();
    end else begin
      if (mq1.size() > 0) e = mq1.pop_front();
    end
  endtask

  // Called at each rising edge with the inputs the DUT samples there.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        if (k == 0) mq0.delete();
        else        mq1.delete();
        cur[k] = IDLE_E;
        rr[k]  = 0;
      end else begin
        if (cur[k].arb && (r0[k] || r1[k])) begin
          int         sel;
          logic [3:0] d;
          logic       par;
          logic [6:0] bits;
          ent_t       e;
          sel = (r0[k] && r1[k]) ? rr[k] : (r1[k] ? 1 : 0);
          d   = (sel == 1) ? d1[k] : d0[k];
          par = ($countones(d) % 2) != 0;
`ifdef UART_ARB_PARITY_INJECT_EN
          par = par ^ ij[k];
`endif
          rr[k] = 1 - sel;
          bits  = {1'b1, par, d[3], d[2], d[1], d[0], 1'b0};
          for (int i = 0; i < 7; i++) begin
            e.tx   = bits[i];
            e.busy = 1'b1;
            e.done = (i == 6);
            e.g0   = (i == 0) && (sel == 0);
            e.g1   = (i == 0) && (sel == 1);
            e.arb  = (i == 6) && (gap_of(k) == 0);
            push_e(k, e);
          end
          for (int j = 0; j < gap_of(k); j++) begin
            e = '{tx: 1'b1, busy: 1'b1, done: 1'b0, g0: 1'b0, g1: 1'b0, arb: 1'b0};
            push_e(k, e);
          end
        end
        pop_e(k, cur[k]);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("tx[%0d]",   k), 16'(tx[k]),   16'(cur[k].tx));
      chk($sformatf("busy[%0d]", k), 16'(busy[k]), 16'(cur[k].busy));
      chk($sformatf("done[%0d]", k), 16'(done[k]), 16'(cur[k].done));
      chk($sformatf("gnt0[%0d]", k), 16'(g0[k]),   16'(cur[k].g0));
      chk($sformatf("gnt1[%0d]", k), 16'(g1[k]),   16'(cur[k].g1));
      chk($sformatf("gnt_excl[%0d]", k), 16'(g0[k] & g1[k]), 16'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Requesters let go once the model says their nibble was accepted.
  task automatic release_on_grant();
    for (int k = 0; k < 2; k++) begin
      if (cur[k].g0) r0[k] = 1'b0;
      if (cur[k].g1) r1[k] = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    r0 = 2'b00;
    r1 = 2'b00;
    repeat (n) tick();
    reset = 1'b1;
  endtask

  task automatic drain(input int n);
    r0 = 2'b00;
    r1 = 2'b00;
    repeat (n) tick();
  endtask

  // Random requester behaviour: re-request or drop on grant, occasionally
  // abandon a request, occasionally raise a new one with fresh data.
  task automatic agent();
    for (int k = 0; k < 2; k++) begin
      if (r0[k]) begin
        if (cur[k].g0) begin
          r0[k] = ($urandom_range(1, 0) == 1);
          d0[k] = 4'($urandom);
        end else if ($urandom_range(15, 0) == 0) begin
          r0[k] = 1'b0;
        end
      end else if ($urandom_range(3, 0) == 0) begin
        r0[k] = 1'b1;
        d0[k] = 4'($urandom);
      end
      if (r1[k]) begin
        if (cur[k].g1) begin
          r1[k] = ($urandom_range(1, 0) == 1);
          d1[k] = 4'($urandom);
        end else if ($urandom_range(15, 0) == 0) begin
          r1[k] = 1'b0;
        end
      end else if ($urandom_range(3, 0) == 0) begin
        r1[k] = 1'b1;
        d1[k] = 4'($urandom);
      end
`ifdef UART_ARB_PARITY_INJECT_EN
      ij[k] = ($urandom_range(3, 0) == 0);
`endif
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed steps followed by a random phase
  // --------------------------------------------------------------------------
  initial begin
    logic [6:0]  cap;
    logic [13:0] cap14;
    int          t0, t1, n;
    int          ord[4];

    reset = 1'b0;
    r0 = 2'b00;
    r1 = 2'b00;
    d0 = '0;
    d1 = '0;
`ifdef UART_ARB_PARITY_INJECT_EN
    ij = 2'b00;
`endif
    foreach (cur[k]) begin
      cur[k] = IDLE_E;
      rr[k]  = 0;
    end

    // Step 1: reset state, then a single frame of 4'b1011.
    repeat (2) begin
      tick();
      chk("rst_tx",   16'(tx[0]),   16'd1);
      chk("rst_busy", 16'(busy[0]), 16'd0);
      chk("rst_gnt",  16'({g0[0], g1[0]}), 16'd0);
      chk("rst_done", 16'(done[0]), 16'd0);
    end
    reset = 1'b1;
    r0 = 2'b11;
    d0[0] = 4'b1011;
    d0[1] = 4'b1011;
    tick();
    cap[0] = tx[0];
    chk("t1_gnt0_start", 16'(g0[0]), 16'd1);
    r0 = 2'b00;
    for (int i = 1; i < 7; i++) begin
      tick();
      cap[i] = tx[0];
      if (i == 6) chk("t1_done_7th", 16'(done[0]), 16'd1);
    end
    chk("t1_frame", 16'(cap), 16'(7'b1110110));
    drain(4);

    // Step 2: simultaneous requests after reset, IDLE_GAP=1 spacing.
    do_reset(1);
    r0 = 2'b11;
    r1 = 2'b11;
    d0[0] = 4'h3; d0[1] = 4'h3;
    d1[0] = 4'h8; d1[1] = 4'h8;
    t0 = -1;
    t1 = -1;
    cap = '0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (g0[0] && t0 < 0) t0 = c;
      if (g1[0] && t1 < 0) t1 = c;
      if (t1 >= 0 && c - t1 < 7) cap[c - t1] = tx[0];
      release_on_grant();
    end
    chk("t2_first_gnt0", 16'(t0), 16'd0);
    chk("t2_start_spacing", 16'(t1 - t0), 16'd9);
    chk("t2_frame2", 16'(cap), 16'(7'b1110000));
    drain(4);

    // Step 3: both requests held, grant order alternates.
    do_reset(1);
    r0 = 2'b11;
    r1 = 2'b11;
    n = 0;
    for (int c = 0; c < 80 && n < 4; c++) begin
      tick();
      if (g0[0]) begin ord[n] = 0; n++; d0[0] = 4'($urandom); end
      else if (g1[0]) begin ord[n] = 1; n++; d1[0] = 4'($urandom); end
    end
    chk("t3_grant_count", 16'(n), 16'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < n) chk($sformatf("t3_order%0d", i), 16'(ord[i]), 16'(i % 2));
    end
    drain(12);

    // Step 4: IDLE_GAP=0, zero nibble held: back-to-back frames.
    do_reset(1);
    r0 = 2'b10;
    d0[1] = 4'b0000;
    for (int i = 0; i < 14; i++) begin
      tick();
      cap14[i] = tx[1];
    end
    chk("t4_back_to_back", 16'(cap14), 16'(14'b10000001000000));
    drain(10);

    // Step 5: reset during D2 aborts the frame and clears the pointer.
    do_reset(1);
    r0 = 2'b11;
    d0[0] = 4'($urandom);
    d0[1] = 4'($urandom);
    tick();            // START
    r0 = 2'b00;
    repeat (3) tick(); // D0, D1, D2
    reset = 1'b0;
    tick();
    chk("t5_abort_tx",   16'(tx),   16'b11);
    chk("t5_abort_busy", 16'(busy), 16'b00);
    chk("t5_abort_done", 16'(done), 16'b00);
    reset = 1'b1;
    r0 = 2'b11;
    r1 = 2'b11;
    tick();
    chk("t5_ptr_reset_gnt0", 16'(g0), 16'b11);
    chk("t5_ptr_reset_gnt1", 16'(g1), 16'b00);
    release_on_grant();
    repeat (12) begin
      tick();
      release_on_grant();
    end
    drain(4);

`ifdef UART_ARB_PARITY_INJECT_EN
    // Step 6: injected parity error on one frame only.
    do_reset(1);
    r0 = 2'b01;
    d0[0] = 4'b0001;
    ij = 2'b01;
    tick();
    r0 = 2'b00;
    ij = 2'b00;
    repeat (5) tick();
    chk("t6_parity_inverted", 16'(tx[0]), 16'd0);
    drain(6);
    r0 = 2'b01;
    tick();
    r0 = 2'b00;
    repeat (5) tick();
    chk("t6_parity_normal", 16'(tx[0]), 16'd1);
    drain(6);
`endif

    // Random phase against the model.
    do_reset(1);
    for (int c = 0; c < 3000; c++) begin
      tick();
      agent();
    end
    drain(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
